pe_pair_queue: RTL

Decoupling queue between the PE geometry stage and the PE accumulate stage. It captures each pair's geometry result (dx, dy, attribute product, squared-distance LUT address) and issues in-order force-LUT requests through a valid/ready handshake. It matches each in-order LUT response to its queued pair and presents a registered, one-cycle accumulate beat (dx, dy, attr_prod, force) to the accumulator.

---
 rtl/pe_pair_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/pe_pair_queue.sv
// pe_pair_queue
//   Decouples the PE geometry stage from the PE accumulate stage. Each
//   geometry result {dx, dy, attr_prod, lut_addr} is queued. Force-LUT
//   requests are issued in order over a valid/ready handshake. Each in-order
//   LUT response is joined with its queued pair and presented as a one-cycle
//   registered accumulate beat.
//
// Ports
//   clk, rstn                : clock, async active-low reset
//   flush                    : synchronous clear of entries/pointers/counters
//   in_valid/in_ready        : geometry input handshake (dx_in, dy_in,
//                              attr_prod_in, lut_addr_in)
//   lut_req_valid/ready      : LUT request handshake, lut_addr_out
//   lut_rsp_valid            : in-order LUT response, lut_data_in
//   acc_valid                : accumulate beat (dx_out, dy_out,
//                              attr_prod_out, force_out)
//   count                    : occupied entries
//   rsp_err                  : sticky, response seen with nothing outstanding
module pe_pair_queue #(
   parameter int DEPTH      = 8,
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic signed [DATA_WIDTH-1:0] dx_in,
   input  logic signed [DATA_WIDTH-1:0] dy_in,
   input  logic signed [ADDR_WIDTH-1:0] attr_prod_in,
   input  logic signed [ADDR_WIDTH-1:0] lut_addr_in,
   output logic                         lut_req_valid,
   input  logic                         lut_req_ready,
   output logic signed [ADDR_WIDTH-1:0] lut_addr_out,
   input  logic                         lut_rsp_valid,
   input  logic signed [DATA_WIDTH-1:0] lut_data_in,
   output logic                         acc_valid,
   output logic signed [DATA_WIDTH-1:0] dx_out,
   output logic signed [DATA_WIDTH-1:0] dy_out,
   output logic signed [ADDR_WIDTH-1:0] attr_prod_out,
   output logic signed [DATA_WIDTH-1:0] force_out,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         rsp_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // Entry storage; no reset needed, occupancy is tracked by the pointers.
   logic signed [DATA_WIDTH-1:0] mem_dx_q   [DEPTH];
   logic signed [DATA_WIDTH-1:0] mem_dy_q   [DEPTH];
   logic signed [ADDR_WIDTH-1:0] mem_attr_q [DEPTH];
   logic signed [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] iss_ptr_q, iss_ptr_d;
   logic [PW-1:0] head_ptr_q, head_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic [CW-1:0] outst_q, outst_d;

   logic                         acc_valid_q, acc_valid_d;
   logic signed [DATA_WIDTH-1:0] dx_out_q, dx_out_d;
   logic signed [DATA_WIDTH-1:0] dy_out_q, dy_out_d;
   logic signed [ADDR_WIDTH-1:0] attr_out_q, attr_out_d;
   logic signed [DATA_WIDTH-1:0] force_out_q, force_out_d;
   logic                         rsp_err_q, rsp_err_d;

   logic do_wr, do_iss, do_pop, do_err;

   // No write-through: a full queue refuses input even if it pops this cycle.
   assign in_ready      = (count_q != FULL);
   assign lut_req_valid = (count_q != outst_q);
   assign lut_addr_out  = mem_addr_q[iss_ptr_q];

   always_comb begin
      // Flush overrides every same-cycle event. A pop needs a request that
      // was outstanding before this edge; a same-cycle issue does not count.
      do_wr  = in_valid && in_ready && !flush;
      do_iss = lut_req_valid && lut_req_ready && !flush;
      do_pop = lut_rsp_valid && (outst_q != '0) && !flush;
      do_err = lut_rsp_valid && (outst_q == '0) && !flush;

      wr_ptr_d    = wr_ptr_q + PW'(do_wr);
      iss_ptr_d   = iss_ptr_q + PW'(do_iss);
      head_ptr_d  = head_ptr_q + PW'(do_pop);
      count_d     = count_q + CW'(do_wr) - CW'(do_pop);
      outst_d     = outst_q + CW'(do_iss) - CW'(do_pop);
      acc_valid_d = do_pop;
      dx_out_d    = dx_out_q;
      dy_out_d    = dy_out_q;
      attr_out_d  = attr_out_q;
      force_out_d = force_out_q;
      rsp_err_d   = rsp_err_q | do_err;

      if (do_pop) begin
         dx_out_d    = mem_dx_q[head_ptr_q];
         dy_out_d    = mem_dy_q[head_ptr_q];
         attr_out_d  = mem_attr_q[head_ptr_q];
         force_out_d = lut_data_in;
      end

      if (flush) begin
         wr_ptr_d   = '0;
         iss_ptr_d  = '0;
         head_ptr_d = '0;
         count_d    = '0;
         outst_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_dx_q[wr_ptr_q]   <= dx_in;
         mem_dy_q[wr_ptr_q]   <= dy_in;
         mem_attr_q[wr_ptr_q] <= attr_prod_in;
         mem_addr_q[wr_ptr_q] <= lut_addr_in;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q    <= '0;
         iss_ptr_q   <= '0;
         head_ptr_q  <= '0;
         count_q     <= '0;
         outst_q     <= '0;
         acc_valid_q <= 1'b0;
         dx_out_q    <= '0;
         dy_out_q    <= '0;
         attr_out_q  <= '0;
         force_out_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         iss_ptr_q   <= iss_ptr_d;
         head_ptr_q  <= head_ptr_d;
         count_q     <= count_d;
         outst_q     <= outst_d;
         acc_valid_q <= acc_valid_d;
         dx_out_q    <= dx_out_d;
         dy_out_q    <= dy_out_d;
         attr_out_q  <= attr_out_d;
         force_out_q <= force_out_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign acc_valid     = acc_valid_q;
   assign dx_out        = dx_out_q;
   assign dy_out        = dy_out_q;
   assign attr_prod_out = attr_out_q;
   assign force_out     = force_out_q;
   assign count         = count_q;
   assign rsp_err       = rsp_err_q;

endmodule
